// File: rtl/sw_debounce_sync.sv
// Slide-switch conditioner: per-bit synchroniser, hold-count debounce FSM, registered level/edge outputs.
// Optional push-to-toggle output o_sw_toggle is enabled by defining SW_DEBOUNCE_TOGGLE_EN.
module sw_debounce_sync #(
  parameter int unsigned N_SW        = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_SW-1:0] i_sw_raw,
  output logic [N_SW-1:0] o_sw,
  output logic [N_SW-1:0] o_sw_rise,
  output logic [N_SW-1:0] o_sw_fall,
`ifdef SW_DEBOUNCE_TOGGLE_EN
  output logic [N_SW-1:0] o_sw_toggle,
`endif
  output logic            o_busy
);

  typedef enum logic [1:0] {SLow, SRchk, SHigh, SFchk} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DB_CYCLES - 1);

  logic [N_SW-1:0] sync_q [SYNC_STAGES];
  logic [N_SW-1:0] s;
  logic [N_SW-1:0] sw_q;
  logic [N_SW-1:0] rise_q;
  logic [N_SW-1:0] fall_q;
  logic [N_SW-1:0] rise_nxt;
  logic [N_SW-1:0] in_chk;
  logic            busy_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= i_sw_raw;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < int'(N_SW); i++) begin : g_bit
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    assign in_chk[i]   = (state_q == SRchk) || (state_q == SFchk);
    // HIGH while the level output is still low can only follow an accepted RCHK exit.
    assign rise_nxt[i] = (state_q == SHigh) && !sw_q[i];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state_q   <= SLow;
        cnt_q     <= '0;
        sw_q[i]   <= 1'b0;
        rise_q[i] <= 1'b0;
        fall_q[i] <= 1'b0;
      end else begin
        sw_q[i]   <= (state_q == SHigh) || (state_q == SFchk);
        rise_q[i] <= rise_nxt[i];
        fall_q[i] <= (state_q == SLow) && sw_q[i];
        unique case (state_q)
          SLow: begin
            if (s[i]) begin
              state_q <= SRchk;
              cnt_q   <= '0;
            end
          end
          SRchk: begin
            if (!s[i]) begin
              state_q <= SLow;
            end else if (cnt_q == CntLast) begin
              state_q <= SHigh;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          SHigh: begin
            if (!s[i]) begin
              state_q <= SFchk;
              cnt_q   <= '0;
            end
          end
          SFchk: begin
            if (s[i]) begin
              state_q <= SHigh;
            end else if (cnt_q == CntLast) begin
              state_q <= SLow;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= |in_chk;
    end
  end

`ifdef SW_DEBOUNCE_TOGGLE_EN
  logic [N_SW-1:0] toggle_q;

  // Flip on the same edge that raises o_sw_rise so the two appear together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_q ^ rise_nxt;
    end
  end

  assign o_sw_toggle = toggle_q;
`endif

  assign o_sw      = sw_q;
  assign o_sw_rise = rise_q;
  assign o_sw_fall = fall_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Bench for sw_debounce_sync: vector table, latency/reset/toggle sequences, random run vs run-length model.
module tb_sw_debounce_sync;

  localparam int N    = 2;
  localparam int SYNC = 2;
  localparam int DB   = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] raw   = 2'b00;
  logic [1:0] sw, rise, fall;
  logic       busy;
`ifdef SW_DEBOUNCE_TOGGLE_EN
  logic [1:0] tog;
`endif

  sw_debounce_sync #(
    .N_SW(N), .SYNC_STAGES(SYNC), .DB_CYCLES(DB), .CNT_W(3)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_sw_raw(raw),
    .o_sw(sw),
    .o_sw_rise(rise),
    .o_sw_fall(fall),
`ifdef SW_DEBOUNCE_TOGGLE_EN
    .o_sw_toggle(tog),
`endif
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: synchronised value is raw delayed SYNC edges; a level is accepted once the
  // synchronised input has disagreed with it for DB+1 consecutive edges; outputs lag by one edge.
  logic [1:0] m_sync [SYNC];
  logic [1:0] m_level, m_sw, m_rise, m_fall, m_tog;
  logic       m_busy;
  int         m_run [N];

  logic [1:0] obs_rise_or, obs_fall_or;
  int         obs_pulse_cycles;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < SYNC; k++) m_sync[k] = '0;
    for (int b = 0; b < N; b++) m_run[b] = 0;
    m_level = '0; m_sw = '0; m_rise = '0; m_fall = '0; m_tog = '0; m_busy = 1'b0;
  endtask

  task automatic tick();
    logic [1:0] s;
    logic       busy_n;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      s      = m_sync[SYNC-1];
      busy_n = 1'b0;
      for (int b = 0; b < N; b++) if (m_run[b] != 0) busy_n = 1'b1;
      m_rise = m_level & ~m_sw;
      m_fall = ~m_level & m_sw;
      m_sw   = m_level;
      m_busy = busy_n;
      m_tog  = m_tog ^ m_rise;
      for (int b = 0; b < N; b++) begin
        if (s[b] != m_level[b]) m_run[b]++;
        else m_run[b] = 0;
        if (m_run[b] == DB + 1) begin
          m_level[b] = ~m_level[b];
          m_run[b]   = 0;
        end
      end
      for (int k = SYNC - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
      m_sync[0] = raw;
    end
    check("o_sw", 32'(sw), 32'(m_sw));
    check("o_sw_rise", 32'(rise), 32'(m_rise));
    check("o_sw_fall", 32'(fall), 32'(m_fall));
    check("o_busy", 32'(busy), 32'(m_busy));
    check("rise_fall_excl", 32'(rise & fall), 32'h0);
`ifdef SW_DEBOUNCE_TOGGLE_EN
    check("o_sw_toggle", 32'(tog), 32'(m_tog));
`endif
    obs_rise_or = obs_rise_or | rise;
    obs_fall_or = obs_fall_or | fall;
    if ((rise | fall) != 2'b00) obs_pulse_cycles++;
  endtask

  typedef struct {
    logic [1:0] raw;
    int         cycles;
    logic [1:0] exp_sw;
    logic [1:0] exp_rise_or;
    logic [1:0] exp_fall_or;
    int         exp_pulse_cycles;
    logic       exp_busy;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int first_sw, rise_cnt, busy_cnt;

    vecs[0] = '{raw: 2'b00, cycles: 20, exp_sw: 2'b00, exp_rise_or: 2'b00, exp_fall_or: 2'b00,
                exp_pulse_cycles: 0, exp_busy: 1'b0};
    vecs[1] = '{raw: 2'b01, cycles: 12, exp_sw: 2'b01, exp_rise_or: 2'b01, exp_fall_or: 2'b00,
                exp_pulse_cycles: 1, exp_busy: 1'b0};
    vecs[2] = '{raw: 2'b11, cycles: 12, exp_sw: 2'b11, exp_rise_or: 2'b10, exp_fall_or: 2'b00,
                exp_pulse_cycles: 1, exp_busy: 1'b0};
    vecs[3] = '{raw: 2'b00, cycles: 12, exp_sw: 2'b00, exp_rise_or: 2'b00, exp_fall_or: 2'b11,
                exp_pulse_cycles: 1, exp_busy: 1'b0};
    vecs[4] = '{raw: 2'b10, cycles: 3, exp_sw: 2'b00, exp_rise_or: 2'b00, exp_fall_or: 2'b00,
                exp_pulse_cycles: 0, exp_busy: 1'b0};
    vecs[5] = '{raw: 2'b00, cycles: 12, exp_sw: 2'b00, exp_rise_or: 2'b00, exp_fall_or: 2'b00,
                exp_pulse_cycles: 0, exp_busy: 1'b0};

    model_reset();
    obs_rise_or = '0; obs_fall_or = '0; obs_pulse_cycles = 0;

    // Asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("reset_sw", 32'(sw), 32'h0);
    check("reset_pulses", 32'({rise, fall}), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      raw = vecs[v].raw;
      obs_rise_or = '0; obs_fall_or = '0; obs_pulse_cycles = 0;
      repeat (vecs[v].cycles) tick();
      check($sformatf("vec%0d_sw", v), 32'(sw), 32'(vecs[v].exp_sw));
      check($sformatf("vec%0d_rise", v), 32'(obs_rise_or), 32'(vecs[v].exp_rise_or));
      check($sformatf("vec%0d_fall", v), 32'(obs_fall_or), 32'(vecs[v].exp_fall_or));
      check($sformatf("vec%0d_npulse", v), 32'(obs_pulse_cycles), 32'(vecs[v].exp_pulse_cycles));
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
    end

    // Step latency: o_sw[0] and rise on the 8th edge counting the sampling edge as 1.
    raw = 2'b01;
    first_sw = 0; rise_cnt = 0; busy_cnt = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (sw[0] && first_sw == 0) first_sw = e;
      if (rise[0]) begin
        rise_cnt++;
        check("step_rise_with_sw", 32'(sw[0]), 32'h1);
      end
      if (busy) busy_cnt++;
    end
    check("step_latency", 32'(first_sw), 32'(SYNC + DB + 2));
    check("step_rise_count", 32'(rise_cnt), 32'h1);
    check("step_busy_cycles", 32'(busy_cnt), 32'(DB));
    raw = 2'b00;
    repeat (12) tick();

    // Reset asserted while bit 0 is qualifying a rise.
    raw = 2'b01;
    repeat (4) tick();
    check("pre_reset_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("midchk_reset_sw", 32'(sw), 32'h0);
    check("midchk_reset_busy", 32'(busy), 32'h0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    first_sw = 0; rise_cnt = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (sw[0] && first_sw == 0) first_sw = e;
      if (rise[0]) rise_cnt++;
    end
    check("requal_latency", 32'(first_sw), 32'(SYNC + DB + 2));
    check("requal_rise_count", 32'(rise_cnt), 32'h1);

`ifdef SW_DEBOUNCE_TOGGLE_EN
    raw = 2'b00;
    #2 rst_n = 1'b0;
    #1 model_reset();
    tick();
    #2 rst_n = 1'b1;
    for (int p = 0; p < 3; p++) begin
      raw = 2'b01;
      repeat (12) tick();
      check($sformatf("toggle_press%0d", p), 32'(tog), (p == 1) ? 32'h0 : 32'h1);
      raw = 2'b00;
      repeat (12) tick();
    end
`endif

    // Random segments of random length against the model.
    for (int r = 0; r < 400; r++) begin
      raw = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 8)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
